// File: rtl/enc_block2.sv
// rtl/enc_block2.sv - 16-bit data to 34-bit diagonal/column parity codeword encoder, two-stage pipeline
// Optional single-bit error injection is compiled in when ENC_ERR_INJECT_EN is defined.
module enc_block2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [33:0] out_cw,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        inj_en,
  input  logic [5:0]  inj_pos,
  output logic [15:0] cw_count
);

  // Stage S1: accepted data word, waiting to be encoded into S2.
  logic        s1_valid;
  logic [15:0] s1_data;

  // Stage S2: encoded codeword presented downstream.
  logic        s2_valid;
  logic [33:0] s2_cw;

  // Handshake helpers.
  logic        accept;
  logic        xfer;
  logic        s2_load;

  // Nibble bits, index 1..4 = most to least significant bit of the nibble.
  logic [4:1]  nib_a;
  logic [4:1]  nib_b;
  logic [4:1]  nib_c;
  logic [4:1]  nib_e;

  // Check bits.
  logic [4:1]  par;
  logic [6:1]  diag;
  logic        hi_a, lo_a, hi_b, lo_b, hi_c, lo_c, hi_e, lo_e;

  // Clean codeword and the codeword actually loaded into S2.
  logic [33:0] enc_cw;
  logic [33:0] s2_next_cw;

`ifdef ENC_ERR_INJECT_EN
  // Injection request travels with its word through S1.
  logic        s1_inj_en;
  logic [5:0]  s1_inj_pos;
`else
  // Injection ports are kept for pin compatibility but have no effect.
  logic        inj_unused;
  assign inj_unused = ^{inj_en, inj_pos};
`endif

  // S2 can take a new value whenever it is empty or its word leaves this cycle.
  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign xfer      = s2_valid && out_ready;
  assign out_valid = s2_valid;
  assign out_cw    = s2_cw;

  // Split the S1 word into named nibbles: bit 1 is the nibble MSB.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    nib_c = '0;
    nib_e = '0;
    for (int k = 1; k <= 4; k++) begin
      nib_a[k] = s1_data[4 - k];
      nib_b[k] = s1_data[8 - k];
      nib_c[k] = s1_data[12 - k];
      nib_e[k] = s1_data[16 - k];
    end
  end

  // Compute row parities, diagonal checks and per-nibble column checks.
  always_comb begin
    par = '0;
    for (int k = 1; k <= 4; k++) begin
      par[k] = nib_a[k] ^ nib_b[k] ^ nib_c[k] ^ nib_e[k];
    end

    diag    = '0;
    diag[1] = nib_a[1] ^ nib_b[2] ^ nib_c[1] ^ nib_e[2];
    diag[2] = nib_b[1] ^ nib_a[2] ^ nib_c[2] ^ nib_e[1];
    diag[3] = nib_a[3] ^ nib_b[4] ^ nib_c[3] ^ nib_e[4];
    diag[4] = nib_b[3] ^ nib_a[4] ^ nib_c[4] ^ nib_e[3];
    diag[5] = nib_a[2] ^ nib_b[3] ^ nib_c[2] ^ nib_e[3];
    diag[6] = nib_b[2] ^ nib_a[3] ^ nib_c[3] ^ nib_e[2];

    hi_a = nib_a[1] ^ nib_a[3];
    lo_a = nib_a[2] ^ nib_a[4];
    hi_b = nib_b[1] ^ nib_b[3];
    lo_b = nib_b[2] ^ nib_b[4];
    hi_c = nib_c[1] ^ nib_c[3];
    lo_c = nib_c[2] ^ nib_c[4];
    hi_e = nib_e[1] ^ nib_e[3];
    lo_e = nib_e[2] ^ nib_e[4];
  end

  // Assemble the codeword in the layout the downstream decoder expects.
  always_comb begin
    enc_cw        = '0;
    enc_cw[15:0]  = s1_data;
    enc_cw[16]    = lo_a;
    enc_cw[17]    = hi_a;
    enc_cw[18]    = par[1];
    enc_cw[19]    = diag[1];
    enc_cw[20]    = lo_b;
    enc_cw[21]    = hi_b;
    enc_cw[22]    = par[2];
    enc_cw[23]    = diag[2];
    enc_cw[24]    = lo_c;
    enc_cw[25]    = hi_c;
    enc_cw[26]    = par[3];
    enc_cw[27]    = diag[3];
    enc_cw[28]    = lo_e;
    enc_cw[29]    = hi_e;
    enc_cw[30]    = par[4];
    enc_cw[31]    = diag[4];
    enc_cw[32]    = diag[5];
    enc_cw[33]    = diag[6];
  end

  // Apply the latched injection; out-of-range positions leave the codeword clean.
  always_comb begin
    s2_next_cw = enc_cw;
`ifdef ENC_ERR_INJECT_EN
    if (s1_inj_en && (s1_inj_pos < 6'd34)) begin
      s2_next_cw = enc_cw ^ (34'd1 << s1_inj_pos);
    end
`endif
  end

  // S1 register: loads on accept, empties when its word moves into S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

`ifdef ENC_ERR_INJECT_EN
  // Injection latches share S1's load condition so they stay aligned with the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inj_en  <= 1'b0;
      s1_inj_pos <= '0;
    end else if (accept) begin
      s1_inj_en  <= inj_en;
      s1_inj_pos <= inj_pos;
    end
  end
`endif

  // S2 register: holds while stalled, otherwise takes S1's encoded word (or empties).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_cw    <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_cw <= s2_next_cw;
      end
    end
  end

  // Delivered-codeword counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_count <= '0;
    end else if (xfer) begin
      cw_count <= cw_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_enc_block2.sv
// tb/tb_enc_block2.sv - self-checking bench for enc_block2 with a queue-based reference model
module tb_enc_block2;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] out_cw;
  logic        out_valid;
  logic        out_ready;
  logic        inj_en;
  logic [5:0]  inj_pos;
  logic [15:0] cw_count;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  logic [33:0] exp_q[$];
  logic        hold_pending = 1'b0;
  logic [33:0] held_cw = '0;

  // Diagonal check membership: for D1..D6, the bit index k used from nibbles A,B,C,E.
  int diag_tab [6][4] = '{'{1,2,1,2}, '{2,1,2,1}, '{3,4,3,4},
                          '{4,3,4,3}, '{2,3,2,3}, '{3,2,3,2}};

  enc_block2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_cw    (out_cw),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
    .cw_count  (cw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder: nibble j (0=A,1=B,2=C,3=E), bit k (1..4) = d[4j+4-k].
  function automatic logic [33:0] ref_cw(input logic [15:0] d);
    logic nb [4][5];
    logic [33:0] cw;
    logic p, hi, lo, dg;
    for (int j = 0; j < 4; j++)
      for (int k = 1; k <= 4; k++)
        nb[j][k] = d[4*j + 4 - k];
    cw = '0;
    cw[15:0] = d;
    for (int j = 0; j < 4; j++) begin
      p  = nb[0][j+1] ^ nb[1][j+1] ^ nb[2][j+1] ^ nb[3][j+1];
      hi = nb[j][1] ^ nb[j][3];
      lo = nb[j][2] ^ nb[j][4];
      dg = 1'b0;
      for (int n = 0; n < 4; n++) dg = dg ^ nb[n][diag_tab[j][n]];
      cw[16 + 4*j] = lo;
      cw[17 + 4*j] = hi;
      cw[18 + 4*j] = p;
      cw[19 + 4*j] = dg;
    end
    for (int i = 4; i < 6; i++) begin
      dg = 1'b0;
      for (int n = 0; n < 4; n++) dg = dg ^ nb[n][diag_tab[i][n]];
      cw[28 + i] = dg;
    end
    return cw;
  endfunction

  function automatic logic [33:0] model_cw(input logic [15:0] d, input logic ie, input logic [5:0] ip);
    logic [33:0] cw;
    cw = ref_cw(d);
`ifdef ENC_ERR_INJECT_EN
    if (ie && ip < 6'd34) cw[ip] = ~cw[ip];
`else
    if (ie && ip > 6'd63) cw = ~cw;
`endif
    return cw;
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at negedge (monitor + scoreboard), then advance to posedge+1.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_valid", {33'd0, out_valid}, 34'd1);
        chk("hold_cw", out_cw, held_cw);
      end
      hold_pending = out_valid && !out_ready;
      held_cw      = out_cw;
      if (out_valid && out_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 34'd1, 34'd0);
        end else begin
          chk("stream_cw", out_cw, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model_cw(in_data, inj_en, inj_pos));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [15:0] vec_d  [4] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h8000};
  logic [33:0] vec_cw [4] = '{34'h000000000, 34'h00000FFFF, 34'h0C0010001, 34'h020848000};

  initial begin
    logic all_ready;
    logic seen_stall;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    inj_en = 1'b0; inj_pos = '0;
    #1;
    chk("reset_in_ready", {33'd0, in_ready}, 34'd1);
    chk("reset_out_valid", {33'd0, out_valid}, 34'd0);
    chk("reset_count", {18'd0, cw_count}, 34'd0);
    chk("reset_out_cw", out_cw, 34'd0);
    do_reset();

    // Fixed encoding vectors with latency check.
    for (int v = 0; v < 4; v++) begin
      in_data = vec_d[v]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lat_not_yet", {33'd0, out_valid}, 34'd0);
      tick();
      chk("lat_valid", {33'd0, out_valid}, 34'd1);
      chk("vector_cw", out_cw, vec_cw[v]);
      tick();
    end

    // Injection: position 5 flips bit 5, position 40 is out of range.
    in_data = 16'h0000; in_valid = 1'b1; inj_en = 1'b1; inj_pos = 6'd5;
    tick();
    inj_pos = 6'd40;
    tick();
    in_valid = 1'b0; inj_en = 1'b0; inj_pos = '0;
`ifdef ENC_ERR_INJECT_EN
    chk("inj_pos5", out_cw, 34'h000000020);
`else
    chk("inj_ignored", out_cw, 34'h000000000);
`endif
    tick();
    chk("inj_pos40", out_cw, 34'h000000000);
    tick(); tick();

    // Streaming: 100 back-to-back random words.
    do_reset();
    xfers = 0;
    all_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 16'($urandom);
      all_ready = all_ready & in_ready;
      tick();
      if (out_valid) chk("syndrome_zero", ref_cw(out_cw[15:0]) ^ out_cw, 34'd0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stream_in_ready", {33'd0, all_ready}, 34'd1);
    chk("stream_count", {18'd0, cw_count}, 34'd100);
    chk("stream_xfers", xfers, 34'd100);
    chk("stream_drained", exp_q.size(), 34'd0);

    // Backpressure: out_ready low for 5 cycles mid-stream, with random injection requests.
    seen_stall = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_data = 16'($urandom);
      inj_en  = 1'($urandom_range(0, 1));
      inj_pos = 6'($urandom_range(0, 63));
      out_ready = !(i >= 10 && i < 15);
      if (i == 14) chk("bp_in_ready_low", {33'd0, in_ready}, 34'd0);
      if (!in_ready) seen_stall = 1'b1;
      tick();
    end
    in_valid = 1'b0; inj_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_stalled", {33'd0, seen_stall}, 34'd1);
    chk("bp_drained", exp_q.size(), 34'd0);
    chk("bp_count", {18'd0, cw_count}, {18'd0, 16'(xfers)});

    // Reset with both stages full.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'($urandom);
      tick();
    end
    chk("full_in_ready", {33'd0, in_ready}, 34'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {33'd0, out_valid}, 34'd0);
    chk("midrst_count", {18'd0, cw_count}, 34'd0);
    chk("midrst_in_ready", {33'd0, in_ready}, 34'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {33'd0, out_valid}, 34'd0);
    in_data = 16'hA5C3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_lat1", {33'd0, out_valid}, 34'd0);
    tick();
    chk("post_rst_lat2", {33'd0, out_valid}, 34'd1);
    chk("post_rst_cw", out_cw, ref_cw(16'hA5C3));
    tick(); tick();

    // Counter wrap: 0xFFFF transfers then one more.
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 70000 && cw_count !== 16'hFFFF; i++) begin
      in_data = 16'($urandom);
      tick();
    end
    chk("wrap_preload", {18'd0, cw_count}, 34'h0FFFF);
    in_valid = 1'b0;
    tick();
    chk("wrap_zero", {18'd0, cw_count}, 34'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("wrap_drained", exp_q.size(), 34'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc_block2.md
ENC_BLOCK2 -- requirements
Module: enc_block2

Interface
REQ-001 SHALL have no parameters; widths are fixed at data 16 bits and codeword 34 bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_data, input, 16 bits: data word to encode.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-007 SHALL have port out_cw, output, 34 bits: codeword, in the field layout the downstream decoder consumes.
REQ-008 SHALL have port out_valid, output, 1 bit: out_cw is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts out_cw.
REQ-010 SHALL have port inj_en, input, 1 bit: arm a single-bit error injection.
REQ-011 SHALL have port inj_pos, input, 6 bits: codeword bit index to flip.
REQ-012 SHALL have port cw_count, output, 16 bits: number of codewords delivered.

Function
REQ-013 SHALL name the nibbles as follows: A1..A4 = d[3],d[2],d[1],d[0]; B1..B4 = d[7..4] in the same order; C1..C4 = d[11..8]; E1..E4 = d[15..12].
REQ-014 SHALL compute the diagonal checks as: D1=A1^B2^C1^E2; D2=B1^A2^C2^E1; D3=A3^B4^C3^E4; D4=B3^A4^C4^E3; D5=A2^B3^C2^E3; D6=B2^A3^C3^E2.
REQ-015 SHALL compute Pk = Ak^Bk^Ck^Ek for k=1..4.
REQ-016 SHALL compute, for each nibble N in {A,B,C,E}, column checks hiN=N1^N3 and loN=N2^N4.
REQ-017 SHALL lay out the codeword as: cw[15:0]=d; cw[16]=loA; cw[17]=hiA; cw[18]=P1; cw[19]=D1; cw[20]=loB; cw[21]=hiB; cw[22]=P2; cw[23]=D2; cw[24]=loC; cw[25]=hiC; cw[26]=P3; cw[27]=D3; cw[28]=loE; cw[29]=hiE; cw[30]=P4; cw[31]=D4; cw[32]=D5; cw[33]=D6.
REQ-018 SHALL use a two-stage pipeline: stage S1 registers accepted data; stage S2 registers the encoded codeword.
REQ-019 SHALL have latency 2 cycles from acceptance (in_valid&&in_ready) to out_valid, when not stalled.
REQ-020 SHALL accept a word on any cycle where in_valid&&in_ready.
REQ-021 SHALL transfer a word on any cycle where out_valid&&out_ready.
REQ-022 SHALL drive in_ready = !S1.valid || !S2.valid || out_ready, combinationally with no dependence on in_valid, so that throughput is one word per cycle.
REQ-023 SHALL hold out_cw and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL NOT drop or duplicate any word.
REQ-025 SHALL, on a simultaneous accept and transfer, advance both stages in the same cycle.
REQ-026 SHALL increment cw_count by 1 on each transfer, wrapping from 0xFFFF to 0x0000.
REQ-027 SHALL, when injection is compiled in (REQ-032), latch inj_en and inj_pos into S1 alongside the word accepted in the same cycle.
REQ-028 SHALL, in S2, XOR bit inj_pos into the codeword only if the latched inj_en=1 and inj_pos<34; for inj_pos≥34, the codeword SHALL be unmodified.

Reset
REQ-029 SHALL, while rst_n=0, clear out_valid, the S1/S2 valid flags, cw_count, out_cw and the injection latches to 0.
REQ-030 SHALL drive in_ready=1 during reset.
REQ-031 SHALL discard in-flight words when reset is asserted mid-operation, and SHALL emit no output until a new word is accepted after release.

Configuration
REQ-032 SHALL, when ENC_ERR_INJECT_EN is defined, implement REQ-027 and REQ-028.
REQ-033 SHALL, when ENC_ERR_INJECT_EN is not defined, keep inj_en and inj_pos as ports but ignore them, always emit the clean codeword, and contain no injection registers.

Verification
REQ-034 SHALL cover encoding: in_data 0x0000 -> out_cw 34'h000000000; 0xFFFF -> 34'h00000FFFF; 0x0001 -> 34'h0C0010001; 0x8000 -> 34'h020848000; each appearing 2 cycles after acceptance.
REQ-035 SHALL cover streaming: 100 back-to-back random words with out_ready=1 -> 100 codewords in order, in_ready constantly 1, cw_count=100, and every codeword decodes back to its data with zero syndrome.
REQ-036 SHALL cover backpressure: out_ready=0 for 5 cycles during a stream -> in_ready falls once both stages are full, out_cw held stable, no loss after out_ready returns to 1.
REQ-037 SHALL cover injection (with ENC_ERR_INJECT_EN): data 0x0000 with inj_en=1, inj_pos=5 -> out_cw=34'h000000020; inj_pos=40 -> 34'h000000000.
REQ-038 SHALL cover reset mid-stream: rst_n pulsed low with both stages full -> out_valid=0 and cw_count=0 immediately; the next accepted word appears 2 cycles after acceptance.
REQ-039 SHALL cover counter wrap: preload 0xFFFF transfers -> one further transfer gives cw_count=0x0000.
